ctl_duck_multi: RTL

- Parametrised successor to the single-duck controller: it manages N_DUCKS independent ducks in the 1024x768 play field.
- Each duck has its own flight state machine, wall reflections, escape, and hit/fall sequence.
- Shots are arbitrated so one shot hits at most one duck, and hit and escape totals are counted.
- Sits in the ctrl section: it is fed by random_number_generator and the mouse click path, and drives the per-duck draw stages.

---
 rtl/ctl_duck_multi_if.sv | 27 ++
 rtl/ctl_duck_multi.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_duck_multi_if.sv
// Bundle between the ctrl section (rng, mouse clicks) and the multi-duck controller.
interface ctl_duck_multi_if #(parameter int N_DUCKS = 4);
    logic                   new_frame;
    logic                   spawn_en;
    logic [9:0]             rnd_start_x;
    logic                   rnd_dir;
    logic [4:0]             rnd_v_spd;
    logic                   shot;
    logic [10:0]            shot_x;
    logic [10:0]            shot_y;
    logic [N_DUCKS*11-1:0]  duck_x;
    logic [N_DUCKS*11-1:0]  duck_y;
    logic [N_DUCKS-1:0]     duck_show;
    logic [N_DUCKS-1:0]     duck_hit;
    logic [7:0]             hit_count;
    logic [7:0]             escape_count;
    logic                   shot_hit;

    modport master (
        output new_frame, spawn_en, rnd_start_x, rnd_dir, rnd_v_spd, shot, shot_x, shot_y,
        input  duck_x, duck_y, duck_show, duck_hit, hit_count, escape_count, shot_hit
    );
    modport slave (
        input  new_frame, spawn_en, rnd_start_x, rnd_dir, rnd_v_spd, shot, shot_x, shot_y,
        output duck_x, duck_y, duck_show, duck_hit, hit_count, escape_count, shot_hit
    );
endinterface

// File: rtl/ctl_duck_multi.sv
// Multi-duck controller: one flight FSM per duck lane, shared spawn timer,
// lowest-index shot arbitration and saturating hit/escape totals.
module ctl_duck_lane #(
    parameter int H_SPEED    = 10,
    parameter int FALL_SPEED = 8,
    parameter int MAX_REFL   = 6,
    parameter int HIT_FRAMES = 30,
    parameter int X_MAX      = 960,
    parameter int Y_MAX      = 600,
    parameter int GROUND_Y   = 640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic        spawn_go,
    input  logic [9:0]  spawn_x,
    input  logic        spawn_dir,
    input  logic [4:0]  spawn_vspd,
    input  logic        hit_go,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        show,
    output logic        hit,
    output logic        fly,
    output logic        idle,
    output logic        esc_evt
);
    typedef enum logic [2:0] {S_IDLE, S_FLY, S_HIT, S_FALL, S_ESC} state_t;

    localparam int RW = $clog2(MAX_REFL + 3);
    localparam int HW = $clog2(HIT_FRAMES + 1);
    localparam logic [11:0]   XM    = 12'(X_MAX);
    localparam logic [11:0]   YM    = 12'(Y_MAX);
    localparam logic [11:0]   HS    = 12'(H_SPEED);
    localparam logic [11:0]   FS    = 12'(FALL_SPEED);
    localparam logic [11:0]   GY    = 12'(GROUND_Y);
    localparam logic [RW-1:0] RMAX  = RW'(MAX_REFL);
    localparam logic [HW-1:0] HLAST = HW'(HIT_FRAMES - 1);

    state_t          st, st_n;
    logic [10:0]     x_n, y_n;
    logic            hd, hd_n, vd, vd_n;   // hd: 1 = right, vd: 1 = down
    logic [4:0]      vs, vs_n;
    logic [RW-1:0]   refl, refl_n, rsum;
    logic [HW-1:0]   hc, hc_n;
    logic [11:0]     xw, yw, vw, tx, ty;
    logic            hr, vr, esc;
    logic            unused_msb;

    assign unused_msb = tx[11] ^ ty[11];

    always_comb begin
        st_n = st; x_n = x; y_n = y; hd_n = hd; vd_n = vd;
        vs_n = vs; refl_n = refl; hc_n = hc; esc_evt = 1'b0;
        xw = {1'b0, x}; yw = {1'b0, y}; vw = {7'd0, vs};
        tx = xw; ty = yw; hr = 1'b0; vr = 1'b0; esc = 1'b0; rsum = refl;
        if (hit_go) begin
            st_n = S_HIT;
            hc_n = '0;
        end else if (new_frame) begin
            case (st)
                S_IDLE: if (spawn_go) begin
                    st_n   = S_FLY;
                    x_n    = ({2'b00, spawn_x} > XM) ? XM[10:0] : {1'b0, spawn_x};
                    y_n    = YM[10:0];
                    hd_n   = spawn_dir;
                    vd_n   = 1'b0;
                    vs_n   = (spawn_vspd == 5'd0) ? 5'd1 : spawn_vspd;
                    refl_n = '0;
                end
                S_FLY: begin
                    if (hd) begin
                        if (xw + HS > XM) begin tx = XM; hr = 1'b1; end
                        else tx = xw + HS;
                    end else begin
                        if (xw < HS) begin tx = '0; hr = 1'b1; end
                        else tx = xw - HS;
                    end
                    if (!vd) begin
                        if (yw < vw) begin
                            if (refl < RMAX) begin ty = '0; vr = 1'b1; end
                            else esc = 1'b1;
                        end else ty = yw - vw;
                    end else begin
                        if (yw + vw > YM) begin ty = YM; vr = 1'b1; end
                        else ty = yw + vw;
                    end
                    rsum = refl + {{(RW-1){1'b0}}, hr} + {{(RW-1){1'b0}}, vr};
                    // an escaping duck freezes in place and leaves the field
                    if (esc) begin
                        st_n    = S_ESC;
                        esc_evt = 1'b1;
                    end else begin
                        x_n    = tx[10:0];
                        y_n    = ty[10:0];
                        hd_n   = hd ^ hr;
                        vd_n   = vd ^ vr;
                        refl_n = (rsum > RMAX) ? RMAX : rsum;
                    end
                end
                S_HIT: begin
                    if (hc == HLAST) st_n = S_FALL;
                    else hc_n = hc + HW'(1);
                end
                S_FALL: begin
                    ty  = yw + FS;
                    y_n = ty[10:0];
                    if (ty >= GY) st_n = S_IDLE;
                end
                S_ESC:   st_n = S_IDLE;
                default: st_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= S_IDLE; x <= '0; y <= '0; hd <= 1'b0; vd <= 1'b0;
            vs <= '0; refl <= '0; hc <= '0;
        end else begin
            st <= st_n; x <= x_n; y <= y_n; hd <= hd_n; vd <= vd_n;
            vs <= vs_n; refl <= refl_n; hc <= hc_n;
        end
    end

    assign show = (st == S_FLY) || (st == S_HIT) || (st == S_FALL);
    assign hit  = (st == S_HIT) || (st == S_FALL);
    assign fly  = (st == S_FLY);
    assign idle = (st == S_IDLE);
endmodule

module ctl_duck_multi #(
    parameter int N_DUCKS      = 4,
    parameter int H_SPEED      = 10,
    parameter int FALL_SPEED   = 8,
    parameter int MAX_REFL     = 6,
    parameter int HIT_FRAMES   = 30,
    parameter int SPAWN_FRAMES = 60,
    parameter int H_RES        = 1024,
    parameter int V_RES        = 768,
    parameter int DUCK_W       = 64,
    parameter int DUCK_H       = 64,
    parameter int SPAWN_Y      = 600,
    parameter int GROUND_Y     = 640
) (
    input  logic              clk,
    input  logic              rst,
    ctl_duck_multi_if.slave   bus
);
    localparam int X_MAX = H_RES - DUCK_W;
    localparam int Y_MAX = (SPAWN_Y < V_RES - DUCK_H) ? SPAWN_Y : V_RES - DUCK_H;
    localparam int SW    = $clog2(SPAWN_FRAMES + 1);
    localparam logic [SW-1:0] SLAST = SW'(SPAWN_FRAMES - 1);
    localparam logic [11:0]   DW    = 12'(DUCK_W);
    localparam logic [11:0]   DH    = 12'(DUCK_H);

    logic [N_DUCKS-1:0][10:0] lx, ly;
    logic [N_DUCKS-1:0]       show, hit, fly, idle, esc_evt, can_hit, hit_sel, spawn_sel;
    logic [SW-1:0]            scnt;
    logic                     spawn_go;
    logic [7:0]               hit_cnt, esc_cnt;
    logic                     shot_hit;
    logic [3:0]               n_esc;
    logic [8:0]               esc_sum;
    logic [11:0]              sx, sy;

    assign sx = {1'b0, bus.shot_x};
    assign sy = {1'b0, bus.shot_y};

    // hit test runs on the registered positions, before this cycle's move
    for (genvar i = 0; i < N_DUCKS; i++) begin : g_hit
        assign can_hit[i] = fly[i] &&
                            ({1'b0, lx[i]} <= sx) && (sx < {1'b0, lx[i]} + DW) &&
                            ({1'b0, ly[i]} <= sy) && (sy < {1'b0, ly[i]} + DH);
    end

    assign spawn_go  = bus.new_frame && bus.spawn_en && (scnt == '0) && (|idle);
    assign hit_sel   = bus.shot ? (can_hit & (~can_hit + N_DUCKS'(1))) : '0;
    assign spawn_sel = spawn_go ? (idle & (~idle + N_DUCKS'(1))) : '0;

    ctl_duck_lane #(
        .H_SPEED(H_SPEED), .FALL_SPEED(FALL_SPEED), .MAX_REFL(MAX_REFL),
        .HIT_FRAMES(HIT_FRAMES), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .GROUND_Y(GROUND_Y)
    ) u_lane [N_DUCKS-1:0] (
        .clk(clk), .rst(rst), .new_frame(bus.new_frame),
        .spawn_go(spawn_sel), .spawn_x(bus.rnd_start_x), .spawn_dir(bus.rnd_dir),
        .spawn_vspd(bus.rnd_v_spd), .hit_go(hit_sel),
        .x(lx), .y(ly), .show(show), .hit(hit), .fly(fly), .idle(idle), .esc_evt(esc_evt)
    );

    always_comb begin
        n_esc = 4'd0;
        for (int i = 0; i < N_DUCKS; i++) n_esc = n_esc + {3'd0, esc_evt[i]};
        esc_sum = {1'b0, esc_cnt} + {5'd0, n_esc};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt     <= SLAST;
            hit_cnt  <= '0;
            esc_cnt  <= '0;
            shot_hit <= 1'b0;
        end else begin
            shot_hit <= |hit_sel;
            if ((|hit_sel) && (hit_cnt != 8'hff)) hit_cnt <= hit_cnt + 8'd1;
            esc_cnt <= esc_sum[8] ? 8'hff : esc_sum[7:0];
            // with no IDLE duck the counter parks at 0 and the spawn stays pending
            if (bus.new_frame && bus.spawn_en) begin
                if (scnt != '0) scnt <= scnt - SW'(1);
                else if (|idle) scnt <= SLAST;
            end
        end
    end

    assign bus.duck_x       = lx;
    assign bus.duck_y       = ly;
    assign bus.duck_show    = show;
    assign bus.duck_hit     = hit;
    assign bus.hit_count    = hit_cnt;
    assign bus.escape_count = esc_cnt;
    assign bus.shot_hit     = shot_hit;
endmodule
